pam_frame_deser: RTL and testbench



---
 rtl/pam_frame_deser.sv | 147 ++++++++++++++
 tb/tb_pam_frame_deser.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_frame_deser.sv
// rtl/pam_frame_deser.sv - PAM-M symbol-to-bit frame deserializer with ping-pong frame banks
//
// Optional feature: define PAM_DESER_FRAME_CNT_EN to add the frame_cnt and
// frame_stall status outputs. The default build omits them.
//
// Each accepted PAM symbol is demapped (natural or Gray) and written MSB-first
// into the bank selected by wb. A completed bank is drained as OUT_WIDTH-bit
// beats, LSB of the beat carrying the earliest frame bit.

module pam_frame_deser #(
  parameter int BITS_PER_SYM = 2,
  parameter int N            = 68,
  parameter int SYMBOL_WIDTH = 8,
  parameter int OUT_WIDTH    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gray_en,
  input  logic [BITS_PER_SYM-1:0] sym_in,
  input  logic                    sym_in_valid,
  output logic                    sym_in_ready,
  output logic [OUT_WIDTH-1:0]    data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
`ifdef PAM_DESER_FRAME_CNT_EN
  output logic [15:0]             frame_cnt,
  output logic                    frame_stall,
`endif
  output logic                    data_out_last
);

  localparam int FRAME_BITS = N * SYMBOL_WIDTH;
  localparam int SYMS       = FRAME_BITS / BITS_PER_SYM;
  localparam int BEATS      = FRAME_BITS / OUT_WIDTH;
  localparam int WCW        = (SYMS  > 1) ? $clog2(SYMS)       : 1;
  localparam int RCW        = (BEATS > 1) ? $clog2(BEATS)      : 1;
  localparam int IDXW       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [WCW-1:0] LAST_SYM  = WCW'(SYMS - 1);
  localparam logic [RCW-1:0] LAST_BEAT = RCW'(BEATS - 1);

  // Reject configurations that cannot tile a frame exactly.
  if (BITS_PER_SYM < 1 || BITS_PER_SYM > 3) begin : g_bad_bps
    $error("pam_frame_deser: BITS_PER_SYM must be 1..3");
  end
  if (FRAME_BITS % BITS_PER_SYM != 0) begin : g_bad_syms
    $error("pam_frame_deser: FRAME_BITS not divisible by BITS_PER_SYM");
  end
  if (FRAME_BITS % OUT_WIDTH != 0) begin : g_bad_beats
    $error("pam_frame_deser: FRAME_BITS not divisible by OUT_WIDTH");
  end

  // Two frame banks; full[k] marks bank k as holding a complete frame.
  logic [FRAME_BITS-1:0]   bank [2];
  logic [1:0]              full;
  logic                    wb;
  logic                    rb;
  logic [WCW-1:0]          wcnt;
  logic [RCW-1:0]          rcnt;

  logic [BITS_PER_SYM-1:0] sym_map;
  logic [BITS_PER_SYM-1:0] sym_rev;
  logic [IDXW-1:0]         wr_base;
  logic [IDXW-1:0]         rd_base;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    wr_last;
  logic                    rd_last;

  // Demap the level index and reverse it so the MSB lands on the lowest frame bit.
  always_comb begin
    sym_map = gray_en ? (sym_in ^ (sym_in >> 1)) : sym_in;
    sym_rev = '0;
    for (int i = 0; i < BITS_PER_SYM; i++) begin
      sym_rev[i] = sym_map[BITS_PER_SYM-1-i];
    end
  end

  // Writer stalls only when the bank it points at still waits to be drained.
  assign sym_in_ready   = !rst && !full[wb];
  assign data_out_valid = full[rb];

  assign wr_fire = sym_in_valid && sym_in_ready;
  assign rd_fire = data_out_valid && data_out_ready;
  assign wr_last = (wcnt == LAST_SYM);
  assign rd_last = (rcnt == LAST_BEAT);

  assign wr_base = IDXW'(wcnt) * IDXW'(BITS_PER_SYM);
  assign rd_base = IDXW'(rcnt) * IDXW'(OUT_WIDTH);

  // Beat is forced to zero whenever nothing is presented, including during reset.
  assign data_out      = full[rb] ? bank[rb][rd_base +: OUT_WIDTH] : '0;
  assign data_out_last = data_out_valid && rd_last;

  // Frame storage carries no reset; validity lives entirely in the full flags.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank[wb][wr_base +: BITS_PER_SYM] <= sym_rev;
    end
  end

  // Write/read pointers, counters and bank flags. wb and rb never address the
  // same bank when both a last write and a last read happen together, so the
  // two flag updates below always touch different bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb   <= 1'b0;
      rb   <= 1'b0;
      wcnt <= '0;
      rcnt <= '0;
      full <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          wcnt     <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_last) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
          rcnt     <= '0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end

`ifdef PAM_DESER_FRAME_CNT_EN
  // Count fully delivered frames; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (rd_fire && rd_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_stall = sym_in_valid && !sym_in_ready;
`endif

endmodule

// File: tb/tb_pam_frame_deser.sv
// tb/tb_pam_frame_deser.sv - randomized scoreboard bench for pam_frame_deser (two configurations)

module tb_pam_frame_deser;

  localparam int A_B = 2, A_N = 68, A_SW = 8, A_OW = 1;
  localparam int A_SYMS = (A_N * A_SW) / A_B;
  localparam int A_BEATS = (A_N * A_SW) / A_OW;
  localparam int B_B = 3, B_N = 3, B_SW = 8, B_OW = 4;
  localparam int B_SYMS = (B_N * B_SW) / B_B;
  localparam int B_BEATS = (B_N * B_SW) / B_OW;

  logic clk;
  logic rst;

  logic            a_gray, a_valid, a_ready, a_dvalid, a_dready, a_last;
  logic [A_B-1:0]  a_sym;
  logic [A_OW-1:0] a_data;
  logic            b_gray, b_valid, b_ready, b_dvalid, b_dready, b_last;
  logic [B_B-1:0]  b_sym;
  logic [B_OW-1:0] b_data;
`ifdef PAM_DESER_FRAME_CNT_EN
  logic [15:0] a_fcnt, b_fcnt;
  logic        a_stall, b_stall;
`endif

  pam_frame_deser #(.BITS_PER_SYM(A_B), .N(A_N), .SYMBOL_WIDTH(A_SW), .OUT_WIDTH(A_OW)) u_dut_a (
    .clk(clk), .rst(rst), .gray_en(a_gray), .sym_in(a_sym), .sym_in_valid(a_valid),
    .sym_in_ready(a_ready), .data_out(a_data), .data_out_valid(a_dvalid),
    .data_out_ready(a_dready),
`ifdef PAM_DESER_FRAME_CNT_EN
    .frame_cnt(a_fcnt), .frame_stall(a_stall),
`endif
    .data_out_last(a_last)
  );

  pam_frame_deser #(.BITS_PER_SYM(B_B), .N(B_N), .SYMBOL_WIDTH(B_SW), .OUT_WIDTH(B_OW)) u_dut_b (
    .clk(clk), .rst(rst), .gray_en(b_gray), .sym_in(b_sym), .sym_in_valid(b_valid),
    .sym_in_ready(b_ready), .data_out(b_data), .data_out_valid(b_dvalid),
    .data_out_ready(b_dready),
`ifdef PAM_DESER_FRAME_CNT_EN
    .frame_cnt(b_fcnt), .frame_stall(b_stall),
`endif
    .data_out_last(b_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int demap(input int s, input bit g);
    return g ? (s ^ (s >> 1)) : s;
  endfunction

  // Stimulus knobs.
  int a_vp, a_rp, b_vp, b_rp;
  int gray_mode;
  int sym_mode;

  // Reference model A: completed-frame bit queue plus the frame being collected.
  bit   a_q[$];
  bit   a_st[$];
  int   a_sc, a_pend, a_beat, a_done, a_acc, a_pat, a_out_beats, a_last_idx;
  logic [7:0] a_log;

  // Reference model B.
  bit   b_q[$];
  bit   b_st[$];
  int   b_sc, b_pend, b_beat, b_done, b_acc, b_out_beats;
  logic [3:0] b_first;

  task automatic model_clear();
    a_q.delete(); a_st.delete();
    a_sc = 0; a_pend = 0; a_beat = 0; a_done = 0; a_acc = 0; a_pat = 0;
    a_out_beats = 0; a_last_idx = -1; a_log = '0;
    b_q.delete(); b_st.delete();
    b_sc = 0; b_pend = 0; b_beat = 0; b_done = 0; b_acc = 0; b_out_beats = 0;
    b_first = '0;
  endtask

  task automatic step_a();
    logic [31:0] e;
    bit          exp_rdy;
    int          m;
    exp_rdy = !rst && (a_pend < 2);
`ifdef PAM_DESER_FRAME_CNT_EN
    check("a_stall", 32'(a_stall), 32'(a_valid && !exp_rdy));
`endif
    if (rst) begin
      check("a_rst_ready", 32'(a_ready), 32'd0);
      check("a_rst_valid", 32'(a_dvalid), 32'd0);
      check("a_rst_data", 32'(a_data), 32'd0);
      check("a_rst_last", 32'(a_last), 32'd0);
      return;
    end
    check("a_ready", 32'(a_ready), 32'(exp_rdy));
    check("a_valid", 32'(a_dvalid), 32'(a_pend > 0));
`ifdef PAM_DESER_FRAME_CNT_EN
    check("a_fcnt", 32'(a_fcnt), a_done & 32'hFFFF);
`endif
    if (a_pend > 0) begin
      e = '0;
      for (int i = 0; i < A_OW; i++) e[i] = a_q[i];
      check("a_data", 32'(a_data), e);
      check("a_last", 32'(a_last), 32'(a_beat == A_BEATS - 1));
      if (a_dready) begin
        if (a_out_beats < 8) a_log[a_out_beats[2:0]] = a_data[0];
        if (a_last && a_last_idx < 0) a_last_idx = a_out_beats;
        a_out_beats++;
        for (int i = 0; i < A_OW; i++) void'(a_q.pop_front());
        a_beat++;
        if (a_beat == A_BEATS) begin
          a_beat = 0; a_pend--; a_done++;
        end
      end
    end
    if (exp_rdy && a_valid) begin
      m = demap(int'(a_sym), a_gray);
      for (int i = 0; i < A_B; i++) a_st.push_back(m[A_B-1-i]);
      a_acc++; a_pat = (a_pat + 1) % 4; a_sc++;
      if (a_sc == A_SYMS) begin
        foreach (a_st[k]) a_q.push_back(a_st[k]);
        a_st.delete(); a_sc = 0; a_pend++;
      end
    end
  endtask

  task automatic step_b();
    logic [31:0] e;
    bit          exp_rdy;
    int          m;
    exp_rdy = !rst && (b_pend < 2);
`ifdef PAM_DESER_FRAME_CNT_EN
    check("b_stall", 32'(b_stall), 32'(b_valid && !exp_rdy));
`endif
    if (rst) begin
      check("b_rst_ready", 32'(b_ready), 32'd0);
      check("b_rst_valid", 32'(b_dvalid), 32'd0);
      check("b_rst_data", 32'(b_data), 32'd0);
      check("b_rst_last", 32'(b_last), 32'd0);
      return;
    end
    check("b_ready", 32'(b_ready), 32'(exp_rdy));
    check("b_valid", 32'(b_dvalid), 32'(b_pend > 0));
`ifdef PAM_DESER_FRAME_CNT_EN
    check("b_fcnt", 32'(b_fcnt), b_done & 32'hFFFF);
`endif
    if (b_pend > 0) begin
      e = '0;
      for (int i = 0; i < B_OW; i++) e[i] = b_q[i];
      check("b_data", 32'(b_data), e);
      check("b_last", 32'(b_last), 32'(b_beat == B_BEATS - 1));
      if (b_dready) begin
        if (b_out_beats == 0) b_first = b_data;
        b_out_beats++;
        for (int i = 0; i < B_OW; i++) void'(b_q.pop_front());
        b_beat++;
        if (b_beat == B_BEATS) begin
          b_beat = 0; b_pend--; b_done++;
        end
      end
    end
    if (exp_rdy && b_valid) begin
      m = demap(int'(b_sym), b_gray);
      for (int i = 0; i < B_B; i++) b_st.push_back(m[B_B-1-i]);
      b_acc++; b_sc++;
      if (b_sc == B_SYMS) begin
        foreach (b_st[k]) b_q.push_back(b_st[k]);
        b_st.delete(); b_sc = 0; b_pend++;
      end
    end
  endtask

  task automatic drive();
    a_valid  = ($urandom_range(99) < a_vp);
    a_dready = ($urandom_range(99) < a_rp);
    b_valid  = ($urandom_range(99) < b_vp);
    b_dready = ($urandom_range(99) < b_rp);
    a_sym = (sym_mode == 0) ? 2'(a_pat) : 2'($urandom_range(3));
    b_sym = (sym_mode == 0) ? 3'd5 : 3'($urandom_range(7));
    a_gray = (gray_mode == 2) ? 1'($urandom_range(1)) : 1'(gray_mode);
    b_gray = (gray_mode == 2) ? 1'($urandom_range(1)) : 1'(gray_mode);
  endtask

  // One clock: check and advance the models mid-cycle, then drive after the edge.
  task automatic cycle();
    @(negedge clk);
    if (rst) model_clear();
    step_a();
    step_b();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_vp = 0; a_rp = 0; b_vp = 0; b_rp = 0;
    gray_mode = 0; sym_mode = 0;
    model_clear();
    drive();
    repeat (3) cycle();
    rst = 1'b0;

    // Natural demap, 0,1,2,3 pattern on A and constant 5 on B, full rate.
    a_vp = 100; a_rp = 100; b_vp = 100; b_rp = 100;
    do_reset();
    repeat (1200) cycle();
    check("a_nat_bits", 32'(a_log), 32'h0000_00D8);
    check("a_last_beat", 32'(a_last_idx), 32'd543);
    check("b_nat_beat", 32'(b_first), 32'd13);
    check("a_frames_ph1", 32'(a_done >= 1), 32'd1);

    // Gray demap.
    gray_mode = 1;
    do_reset();
    repeat (700) cycle();
    check("a_gray_bits", 32'(a_log), 32'h0000_0078);
    check("b_gray_beat", 32'(b_first), 32'd15);

    // Output blocked: exactly two frames buffered, then release.
    gray_mode = 2; sym_mode = 1;
    a_rp = 0; b_rp = 0;
    do_reset();
    repeat (700) cycle();
    check("a_stall_acc", 32'(a_acc), 32'(2 * A_SYMS));
    check("a_stall_ready", 32'(a_ready), 32'd0);
    check("b_stall_acc", 32'(b_acc), 32'(2 * B_SYMS));
    a_rp = 100; b_rp = 100;
    repeat (2000) cycle();
    check("a_drain_frames", 32'(a_done >= 3), 32'd1);

    // Random handshake pressure on both sides.
    for (int p = 0; p < 4; p++) begin
      a_vp = int'($urandom_range(100, 30)); a_rp = int'($urandom_range(100, 30));
      b_vp = int'($urandom_range(100, 30)); b_rp = int'($urandom_range(100, 30));
      repeat (1500) cycle();
    end
    check("b_random_frames", 32'(b_done > 0), 32'd1);

    // Reset in the middle of a frame, then a fresh frame.
    gray_mode = 0; sym_mode = 0;
    a_vp = 100; a_rp = 100; b_vp = 100; b_rp = 100;
    do_reset();
    for (int i = 0; i < 500 && a_acc < 100; i++) cycle();
    check("a_mid_reach", 32'(a_acc), 32'd100);
    do_reset();
    repeat (900) cycle();
    check("a_fresh_frames", 32'(a_done), 32'd1);
    check("a_fresh_bits", 32'(a_log), 32'h0000_00D8);
`ifdef PAM_DESER_FRAME_CNT_EN
    check("a_fresh_fcnt", 32'(a_fcnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
